uart_record_framer_axis: RTL and testbench
==========================================

Name: uart_record_framer_axis

Overview:
- Successor to the fixed 32-byte UART-to-AXIS record packer in the stage3 timestamp path.
- Hunts for a configurable sync byte, then collects RECORD_BYTES payload bytes into one wide word. Aborts partial records on an inter-byte timeout.
- Buffers completed records in a small FIFO so downstream back-pressure does not lose data.
- Sits between the UART RX core and the record-consuming AXIS logic (timestamp/orderbook stage). Exposes saturating status counters for PS readback.

Parameters:
- RECORD_BYTES, 32, payload bytes per record (2..64); tdata width = 8*RECORD_BYTES.
- SYNC_EN, 1, 1 = hunt for SYNC_BYTE before each record; 0 = records are back-to-back from reset.
- SYNC_BYTE, 8'hA5, framing byte; consumed, never packed into tdata.
- TIMEOUT_CYCLES, 100000, idle clk cycles inside a record before abort; 0 disables the timeout.
- FIFO_DEPTH, 4, completed-record buffer depth (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rx_valid  in  1  one-cycle strobe, byte available.
- uart_rx_data  in  8  received byte.
- m_axis_tdata  out  8*RECORD_BYTES  record; byte k at [8k+7:8k].
- m_axis_tvalid  out  1  record available.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  equals m_axis_tvalid (one beat per record).
- stat_records  out  16  records pushed into FIFO, saturating.
- stat_overflow  out  16  completed records dropped because FIFO full, saturating.
- stat_timeouts  out  16  partial records aborted by timeout, saturating.
- busy  out  1  high while in COLLECT.

Behaviour:
- Reset (async, rst=1) clears the following to 0:
  - all outputs and counters;
  - FIFO pointers;
  - byte index and timeout counter.
- Reset state is HUNT if SYNC_EN=1, else COLLECT. Reset mid-record discards the partial record and all buffered records.
- HUNT:
  - valid byte == SYNC_BYTE -> COLLECT, byte index 0, timeout counter 0.
  - Any other byte is dropped silently.
- COLLECT:
  - Each valid byte is written to the assembly register at lane index, and the index increments.
  - On lane RECORD_BYTES-1 the assembled word, including this byte, is pushed into the FIFO in the same cycle.
  - Next state after completion: HUNT (SYNC_EN=1) or COLLECT with index 0 (SYNC_EN=0).
  - A sync-valued byte inside COLLECT is ordinary payload.
- Timeout:
  - The counter increments each cycle in COLLECT without uart_rx_valid and clears on a valid byte.
  - Counter reaching TIMEOUT_CYCLES-1 with no byte that cycle -> abort: stat_timeouts++, index 0, state HUNT (or COLLECT when SYNC_EN=0).
  - A byte arriving in the expiry cycle wins; no abort.
  - The timeout is inactive in HUNT and when TIMEOUT_CYCLES=0.
- Assembly register lanes are not cleared between records. Only complete records are ever emitted.
- FIFO:
  - Push on record completion. Pop on tvalid && tready.
  - Full and no pop -> record dropped, stat_overflow++, stat_records unchanged.
  - Full with simultaneous pop -> push accepted.
  - Push into an empty FIFO -> tvalid high the next cycle (latency 1 clk from last-byte strobe).
  - tdata/tvalid hold stable while tvalid && !tready (AXIS rule).
  - Back-to-back pops are allowed; tvalid deasserts the cycle after the last entry pops.
- Counters saturate at 16'hFFFF; no wrap.
- busy = (state == COLLECT) && (index != 0 || SYNC_EN=1).

Decomposition:
- Package uart_rec_pkg:
  - state enum {HUNT, COLLECT};
  - STAT_W = 16;
  - function clog2-safe index width for RECORD_BYTES.
- Sub-module record_fifo:
  - parametrised width/depth synchronous FIFO, registered output, async active-high reset;
  - push/pop/full/empty, push-when-full-with-pop allowed.
- Top level holds the framer FSM, timeout counter, assembly register and counters.

Test Plan:
- SYNC_EN=1, RECORD_BYTES=4, send A5 01 02 03 04 with tready=1 -> one beat, tdata=32'h04030201, tlast=1, stat_records=1.
- Send 11 22 A5 10 20 30 40 -> 11, 22 dropped; tdata=32'h40302010; then A5 A5 B1 B2 B3 -> tdata=32'hB3B2B1A5 (second A5 is payload).
- TIMEOUT_CYCLES=50: A5 01 02, idle 60 cycles, then A5 05 06 07 08 -> stat_timeouts=1, single output 32'h08070605.
- FIFO_DEPTH=2, tready=0, send 3 full records -> stat_records=2, stat_overflow=1; raise tready -> first two records emitted in order, tvalid then low.
- Assert rst mid-record (after A5 01) with one record buffered -> tvalid=0, counters 0 immediately. Next full record emits correctly.
- SYNC_EN=0, stream 8 bytes 00..07 -> two records 32'h03020100, 32'h07060504 with no sync needed.

Source files
------------

// File: rtl/uart_rec_pkg.sv
// Shared types and helpers for the UART record framer: FSM state encoding,
// status counter width and index-width sizing.
package uart_rec_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  // Width able to hold 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/record_fifo.sv
// Synchronous record FIFO with registered storage; a push while full is
// accepted only when a pop happens in the same cycle.
module record_fifo
  import uart_rec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = idx_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage is cleared on reset so the exposed head word reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_record_framer_axis.sv
// Frames UART bytes into fixed-length records (optional sync byte, inter-byte
// timeout) and presents them as single-beat AXIS transfers via a small FIFO.
module uart_record_framer_axis
  import uart_rec_pkg::*;
#(
  parameter int          RECORD_BYTES   = 32,
  parameter int          SYNC_EN        = 1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_rx_valid,
  input  logic [7:0]                uart_rx_data,
  output logic [8*RECORD_BYTES-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [STAT_W-1:0]         stat_records,
  output logic [STAT_W-1:0]         stat_overflow,
  output logic [STAT_W-1:0]         stat_timeouts,
  output logic                      busy
);

  localparam int DW    = 8 * RECORD_BYTES;
  localparam int IDX_W = idx_width(RECORD_BYTES);
  localparam int TMO_W = idx_width(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RECORD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam state_t RST_STATE  = (SYNC_EN != 0) ? HUNT : COLLECT;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DW-1:0]     asm_q, push_data;
  logic [STAT_W-1:0] rec_q, ovf_q, tmo_cnt_q;
  logic              push, asm_we, tmo_abort, in_record;
  logic              fifo_full, fifo_empty, pop, ovf_drop;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

  // Idle time only matters once a record is actually underway.
  assign in_record = (state_q == COLLECT) && ((idx_q != '0) || (SYNC_EN != 0));

  always_comb begin
    push_data = asm_q;
    push_data[8*idx_q +: 8] = uart_rx_data;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    asm_we    = 1'b0;
    tmo_abort = 1'b0;
    case (state_q)
      HUNT: begin
        if (uart_rx_valid && (uart_rx_data == SYNC_BYTE)) begin
          state_d = COLLECT;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      COLLECT: begin
        if (uart_rx_valid) begin
          asm_we = 1'b1;
          tmo_d  = '0;
          if (idx_q == IDX_LAST) begin
            push    = 1'b1;
            idx_d   = '0;
            state_d = RST_STATE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (in_record && (TIMEOUT_CYCLES != 0)) begin
          if (tmo_q == TMO_LAST) begin
            tmo_abort = 1'b1;
            tmo_d     = '0;
            idx_d     = '0;
            state_d   = RST_STATE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
    end
  end

  // Lanes persist across records; only complete records ever leave the block.
  always_ff @(posedge clk) begin
    if (asm_we) asm_q <= push_data;
  end

  assign pop      = m_axis_tvalid && m_axis_tready;
  assign ovf_drop = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q     <= '0;
      ovf_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (push && !ovf_drop) rec_q <= sat_inc(rec_q);
      if (ovf_drop)          ovf_q <= sat_inc(ovf_q);
      if (tmo_abort)         tmo_cnt_q <= sat_inc(tmo_cnt_q);
    end
  end

  record_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .data_o      (m_axis_tdata)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid;
  assign stat_records  = rec_q;
  assign stat_overflow = ovf_q;
  assign stat_timeouts = tmo_cnt_q;
  assign busy          = in_record;

endmodule

// File: tb/tb_uart_record_framer_axis.sv
// Directed bench: a sync-hunting framer (4-byte records, 50-cycle timeout,
// 2-deep FIFO) and a free-running framer without sync.
module tb_uart_record_framer_axis;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v1, tr1, tv1, tl1, b1;
  logic [7:0]  d1;
  logic [31:0] td1;
  logic [15:0] sr1, so1, st1;
  logic        v0, tr0, tv0, tl0, b0;
  logic [7:0]  d0;
  logic [31:0] td0;
  logic [15:0] sr0, so0, st0;

  int errors = 0;
  int checks = 0;

  uart_record_framer_axis #(
    .RECORD_BYTES(4), .SYNC_EN(1), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50), .FIFO_DEPTH(2)
  ) u_dut (
    .clk(clk), .rst(rst), .uart_rx_valid(v1), .uart_rx_data(d1),
    .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(tr1), .m_axis_tlast(tl1),
    .stat_records(sr1), .stat_overflow(so1), .stat_timeouts(st1), .busy(b1)
  );

  uart_record_framer_axis #(
    .RECORD_BYTES(4), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50), .FIFO_DEPTH(2)
  ) u_dut0 (
    .clk(clk), .rst(rst), .uart_rx_valid(v0), .uart_rx_data(d0),
    .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(tr0), .m_axis_tlast(tl0),
    .stat_records(sr0), .stat_overflow(so0), .stat_timeouts(st0), .busy(b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [7:0] b);
    v1 = 1'b1;
    d1 = b;
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b);
    v0 = 1'b1;
    d0 = b;
    @(posedge clk); #1;
    v0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rec1(input logic [7:0] b0_, input logic [7:0] b1_,
                      input logic [7:0] b2_, input logic [7:0] b3_);
    send1(8'hA5); send1(b0_); send1(b1_); send1(b2_); send1(b3_);
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; d1 = 8'h00; tr1 = 1'b1;
    v0 = 1'b0; d0 = 8'h00; tr0 = 1'b1;
    #2;
    chk("rst_tvalid", {31'b0, tv1}, 32'd0);
    chk("rst_tdata", td1, 32'h0);
    chk("rst_records", {16'b0, sr1}, 32'd0);
    chk("rst_busy", {31'b0, b1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Basic record
    send1(8'hA5);
    chk("busy_after_sync", {31'b0, b1}, 32'd1);
    send1(8'h01); send1(8'h02); send1(8'h03); send1(8'h04);
    chk("rec1_tvalid", {31'b0, tv1}, 32'd1);
    chk("rec1_tdata", td1, 32'h04030201);
    chk("rec1_tlast", {31'b0, tl1}, 32'd1);
    chk("rec1_records", {16'b0, sr1}, 32'd1);
    chk("rec1_busy_done", {31'b0, b1}, 32'd0);
    idle(1);
    chk("rec1_tvalid_low", {31'b0, tv1}, 32'd0);

    // Junk before sync, then sync byte as payload
    send1(8'h11); send1(8'h22);
    rec1(8'h10, 8'h20, 8'h30, 8'h40);
    chk("junk_tdata", td1, 32'h40302010);
    chk("junk_records", {16'b0, sr1}, 32'd2);
    idle(1);
    rec1(8'hA5, 8'hB1, 8'hB2, 8'hB3);
    chk("sync_payload_tdata", td1, 32'hB3B2B1A5);
    idle(1);

    // Timeout abort
    send1(8'hA5); send1(8'h01); send1(8'h02);
    idle(60);
    chk("tmo_count", {16'b0, st1}, 32'd1);
    chk("tmo_busy", {31'b0, b1}, 32'd0);
    chk("tmo_no_output", {31'b0, tv1}, 32'd0);
    rec1(8'h05, 8'h06, 8'h07, 8'h08);
    chk("tmo_after_tdata", td1, 32'h08070605);
    idle(1);
    chk("tmo_single_out", {31'b0, tv1}, 32'd0);

    // Byte arriving in the expiry cycle wins
    send1(8'hA5);
    idle(49);
    send1(8'h11); send1(8'h22); send1(8'h33); send1(8'h44);
    chk("expiry_tdata", td1, 32'h44332211);
    chk("expiry_no_abort", {16'b0, st1}, 32'd1);
    idle(1);

    // Overflow with back-pressure
    rst = 1'b1; #1; rst = 1'b0;
    idle(1);
    tr1 = 1'b0;
    rec1(8'h01, 8'h02, 8'h03, 8'h04);
    rec1(8'h11, 8'h12, 8'h13, 8'h14);
    rec1(8'h21, 8'h22, 8'h23, 8'h24);
    chk("ovf_records", {16'b0, sr1}, 32'd2);
    chk("ovf_overflow", {16'b0, so1}, 32'd1);
    idle(2);
    chk("ovf_hold_tvalid", {31'b0, tv1}, 32'd1);
    chk("ovf_hold_tdata", td1, 32'h04030201);
    tr1 = 1'b1;
    idle(1);
    chk("ovf_second_tvalid", {31'b0, tv1}, 32'd1);
    chk("ovf_second_tdata", td1, 32'h14131211);
    idle(1);
    chk("ovf_drained", {31'b0, tv1}, 32'd0);

    // Reset mid-record with a buffered record
    tr1 = 1'b0;
    rec1(8'h31, 8'h32, 8'h33, 8'h34);
    chk("mid_buffered", {31'b0, tv1}, 32'd1);
    send1(8'hA5); send1(8'h01);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", {31'b0, tv1}, 32'd0);
    chk("mid_rst_tdata", td1, 32'h0);
    chk("mid_rst_records", {16'b0, sr1}, 32'd0);
    chk("mid_rst_overflow", {16'b0, so1}, 32'd0);
    chk("mid_rst_busy", {31'b0, b1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tr1 = 1'b1;
    rec1(8'h41, 8'h42, 8'h43, 8'h44);
    chk("post_rst_tdata", td1, 32'h44434241);
    chk("post_rst_records", {16'b0, sr1}, 32'd1);
    idle(1);

    // No-sync mode
    send0(8'h00);
    chk("nosync_busy", {31'b0, b0}, 32'd1);
    send0(8'h01); send0(8'h02); send0(8'h03);
    chk("nosync_rec0_tvalid", {31'b0, tv0}, 32'd1);
    chk("nosync_rec0_tdata", td0, 32'h03020100);
    send0(8'h04); send0(8'h05); send0(8'h06); send0(8'h07);
    chk("nosync_rec1_tdata", td0, 32'h07060504);
    chk("nosync_records", {16'b0, sr0}, 32'd2);
    idle(60);
    chk("nosync_idle_no_tmo", {16'b0, st0}, 32'd0);
    chk("nosync_drained", {31'b0, tv0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
